// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet-layer parser: strips header/CRC from long packets into a video stream, turns FS/FE into pulses.
// Define CSI2_PAYLOAD_CRC_EN to build the payload CRC-16 checker driving crc_err_o.
`timescale 1ns/1ps
module csi2_pkt_parser #(
  parameter logic [5:0] DATA_TYPE       = 6'h2B,
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pkt_tdata_i,
  input  logic [3:0]  pkt_tstrb_i,
  input  logic        pkt_tvalid_i,
  input  logic        pkt_tlast_i,
  output logic [31:0] video_tdata_o,
  output logic [3:0]  video_tstrb_o,
  output logic        video_tvalid_o,
  output logic        video_tlast_o,
  output logic        video_tuser_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] frame_num_o,
  output logic        pkt_err_o,
  output logic        crc_err_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP} state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        sof_pending_q, sof_pending_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic [31:0] video_tdata_q, video_tdata_d;
  logic [3:0]  video_tstrb_q, video_tstrb_d;
  logic        video_tvalid_q, video_tvalid_d;
  logic        video_tlast_q, video_tlast_d;
  logic        video_tuser_q, video_tuser_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        pkt_err_q, pkt_err_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [2:0]  beat_n;
  logic        hdr_accept;
  logic        payload_beat;
  logic        unused_tstrb;

  assign hdr_dt       = pkt_tdata_i[5:0];
  assign hdr_vc       = pkt_tdata_i[7:6];
  assign hdr_wc       = pkt_tdata_i[23:8];
  assign beat_n       = (rem_q > 16'd4) ? 3'd4 : rem_q[2:0];
  assign hdr_accept   = (state_q == ST_IDLE) && pkt_tvalid_i && !pkt_tlast_i &&
                        (hdr_dt >= 6'h10) && (hdr_dt == DATA_TYPE) &&
                        (hdr_vc == VIRTUAL_CHANNEL) && (hdr_wc != 16'd0);
  assign payload_beat = (state_q == ST_PAYLOAD) && pkt_tvalid_i;
  // Input strobes carry no information here: the byte count comes from WC.
  assign unused_tstrb = ^pkt_tstrb_i;

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    sof_pending_d  = sof_pending_q;
    frame_num_d    = frame_num_q;
    video_tdata_d  = 32'd0;
    video_tstrb_d  = 4'd0;
    video_tvalid_d = 1'b0;
    video_tlast_d  = 1'b0;
    video_tuser_d  = 1'b0;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    pkt_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pkt_tvalid_i) begin
          if (hdr_dt < 6'h10) begin
            if (hdr_dt == 6'h00) begin
              frame_start_d = 1'b1;
              frame_num_d   = hdr_wc;
              sof_pending_d = 1'b1;
            end else if (hdr_dt == 6'h01) begin
              frame_end_d = 1'b1;
            end
          end else if (hdr_accept) begin
            rem_d   = hdr_wc;
            state_d = ST_PAYLOAD;
          end else if (!pkt_tlast_i) begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pkt_tvalid_i) begin
          // Words holding only CRC bytes (rem == 0) produce no output beat.
          if (rem_q != 16'd0) begin
            video_tvalid_d = 1'b1;
            video_tdata_d  = pkt_tdata_i;
            for (int i = 0; i < 4; i++) video_tstrb_d[i] = (i < int'(beat_n));
            video_tlast_d  = (rem_q <= 16'd4) || pkt_tlast_i;
            video_tuser_d  = sof_pending_q;
            sof_pending_d  = 1'b0;
            pkt_err_d      = pkt_tlast_i && (rem_q > 16'd4);
            rem_d          = rem_q - {13'd0, beat_n};
          end
          if (pkt_tlast_i) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (pkt_tvalid_i && pkt_tlast_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      rem_q          <= 16'd0;
      sof_pending_q  <= 1'b0;
      frame_num_q    <= 16'd0;
      video_tdata_q  <= 32'd0;
      video_tstrb_q  <= 4'd0;
      video_tvalid_q <= 1'b0;
      video_tlast_q  <= 1'b0;
      video_tuser_q  <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      pkt_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      sof_pending_q  <= sof_pending_d;
      frame_num_q    <= frame_num_d;
      video_tdata_q  <= video_tdata_d;
      video_tstrb_q  <= video_tstrb_d;
      video_tvalid_q <= video_tvalid_d;
      video_tlast_q  <= video_tlast_d;
      video_tuser_q  <= video_tuser_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      pkt_err_q      <= pkt_err_d;
    end
  end

  assign video_tdata_o  = video_tdata_q;
  assign video_tstrb_o  = video_tstrb_q;
  assign video_tvalid_o = video_tvalid_q;
  assign video_tlast_o  = video_tlast_q;
  assign video_tuser_o  = video_tuser_q;
  assign frame_start_o  = frame_start_q;
  assign frame_end_o    = frame_end_q;
  assign frame_num_o    = frame_num_q;
  assign pkt_err_o      = pkt_err_q;

`ifdef CSI2_PAYLOAD_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_rx_q, crc_rx_d;
  logic [1:0]  crc_cnt_q, crc_cnt_d;
  logic        crc_err_q, crc_err_d;

  // Reflected form of x^16+x^12+x^5+1 so bits are consumed LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ data[b]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    crc_d     = crc_q;
    crc_rx_d  = crc_rx_q;
    crc_cnt_d = crc_cnt_q;
    crc_err_d = 1'b0;
    if (hdr_accept) begin
      crc_d     = 16'hFFFF;
      crc_rx_d  = 16'd0;
      crc_cnt_d = 2'd0;
    end else if (payload_beat) begin
      // Bytes past the payload are the received CRC, low byte first, possibly split across words.
      for (int i = 0; i < 4; i++) begin
        if (i < int'(beat_n)) begin
          crc_d = crc16_byte(crc_d, pkt_tdata_i[8*i +: 8]);
        end else if (crc_cnt_d != 2'd2) begin
          if (crc_cnt_d == 2'd0) crc_rx_d[7:0]  = pkt_tdata_i[8*i +: 8];
          else                   crc_rx_d[15:8] = pkt_tdata_i[8*i +: 8];
          crc_cnt_d = crc_cnt_d + 2'd1;
        end
      end
      crc_err_d = pkt_tlast_i && (crc_d != crc_rx_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q     <= 16'd0;
      crc_rx_q  <= 16'd0;
      crc_cnt_q <= 2'd0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_rx_q  <= crc_rx_d;
      crc_cnt_q <= crc_cnt_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err_o = crc_err_q;
`else
  assign crc_err_o = 1'b0;
`endif

endmodule
